// File: rtl/msx_slot_pkg.sv
// Shared types for the MSX slot expander: slot index encoding and wait FSM states.
package msx_slot_pkg;

  localparam logic [15:0] SUBSLOT_REG_ADDR = 16'hFFFF;

  typedef logic [3:0] slot_idx_t;

  typedef enum logic [1:0] {IDLE, MIN, POLL, DONE} wait_state_t;

  function automatic slot_idx_t make_idx(input logic [1:0] p, input logic [1:0] s);
    return {p, s};
  endfunction

endpackage

// File: rtl/slot_wait_ctrl.sv
// Z80 wait-state generator: minimum wait, then poll slot_ready with a saturating timeout guard.
module slot_wait_ctrl
  import msx_slot_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        mreq_n,
  input  logic        sel_valid,
  input  slot_idx_t   sel,
  input  logic [15:0] slot_ready,
  output logic        wait_n,
  output logic        timeout_flag,
  output logic        force_ff
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
  localparam logic [MW-1:0] MIN_LAST = MW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  wait_state_t   state;
  logic          mreq_prev;
  logic [MW-1:0] min_cnt;
  logic [CW-1:0] to_cnt;
  slot_idx_t     sel_q;

  // Select is latched on entry so a mid-access register write only affects the next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_n       <= 1'b1;
      timeout_flag <= 1'b0;
      force_ff     <= 1'b0;
      mreq_prev    <= 1'b1;
      min_cnt      <= '0;
      to_cnt       <= '0;
      sel_q        <= '0;
    end else if (clk_en) begin
      mreq_prev <= mreq_n;
      case (state)
        IDLE: begin
          wait_n   <= 1'b1;
          force_ff <= 1'b0;
          if (!mreq_n && mreq_prev && sel_valid) begin
            sel_q   <= sel;
            min_cnt <= '0;
            to_cnt  <= '0;
            wait_n  <= 1'b0;
            state   <= (WAIT_STATES > 0) ? MIN : POLL;
          end
        end
        MIN: begin
          if (mreq_n) begin
            state  <= IDLE;
            wait_n <= 1'b1;
          end else if (min_cnt == MIN_LAST) begin
            state <= POLL;
          end else begin
            min_cnt <= min_cnt + 1'b1;
          end
        end
        POLL: begin
          if (mreq_n) begin
            state  <= IDLE;
            wait_n <= 1'b1;
          end else if (slot_ready[sel_q]) begin
            state  <= DONE;
            wait_n <= 1'b1;
          end else if (to_cnt == TO_MAX) begin
            state        <= DONE;
            wait_n       <= 1'b1;
            timeout_flag <= 1'b1;
            force_ff     <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          wait_n <= 1'b1;
          if (mreq_n) begin
            state    <= IDLE;
            force_ff <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/slot_expander.sv
// MSX primary/secondary slot selector: slot registers, SLTSL_n decode and CPU read-data mux.
module slot_expander
  import msx_slot_pkg::*;
#(
  parameter int         NUM_PRIMARY = 4,
  parameter logic [3:0] EXPANDED    = 4'b1000,
  parameter logic [7:0] PSLOT_PORT  = 8'hA8,
  parameter int         WAIT_STATES = 0,
  parameter int         TIMEOUT     = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic [15:0]  addr,
  input  logic         mreq_n,
  input  logic         iorq_n,
  input  logic         rd_n,
  input  logic         wr_n,
  input  logic         rfsh_n,
  input  logic [7:0]   d_from_cpu,
  output logic [7:0]   d_to_cpu,
  input  logic [127:0] slot_d,
  input  logic [15:0]  slot_ready,
  output logic [15:0]  sltsl_n,
  output logic         wait_n,
  output logic         timeout_flag,
  output logic [7:0]   pslot_reg
);

  logic [7:0] sub_reg [4];
  logic       wr_seen;
  logic [1:0] pg, page_p, sub_s;
  logic       p_impl, sub_hit, io_hit, sel_valid, force_ff;
  slot_idx_t  idx;

  always_comb begin
    pg      = addr[15:14];
    page_p  = pslot_reg[{pg, 1'b0} +: 2];
    sub_s   = EXPANDED[page_p] ? sub_reg[page_p][{pg, 1'b0} +: 2] : 2'b00;
    idx     = make_idx(page_p, sub_s);
    p_impl  = ({1'b0, page_p} < 3'(NUM_PRIMARY));
    sub_hit = !mreq_n && rfsh_n && (addr == SUBSLOT_REG_ADDR) && EXPANDED[page_p] && p_impl;
    io_hit  = !iorq_n && rfsh_n && (addr[7:0] == PSLOT_PORT);
    sel_valid = !mreq_n && rfsh_n && p_impl && !sub_hit;
  end

  assign sltsl_n = sel_valid ? ~(16'd1 << idx) : '1;

  // A strobe held over several clk_en cycles writes only once, on its first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pslot_reg <= '0;
      for (int unsigned i = 0; i < 4; i++) sub_reg[i] <= '0;
      wr_seen   <= 1'b0;
    end else if (clk_en) begin
      wr_seen <= !wr_n && (io_hit || sub_hit);
      if (!wr_seen && !wr_n) begin
        if (io_hit)  pslot_reg       <= d_from_cpu;
        if (sub_hit) sub_reg[page_p] <= d_from_cpu;
      end
    end
  end

  always_comb begin
    d_to_cpu = 8'hFF;
    if (!rd_n) begin
      if (io_hit)                       d_to_cpu = pslot_reg;
      else if (sub_hit)                 d_to_cpu = ~sub_reg[page_p];
      else if (sel_valid && !force_ff)  d_to_cpu = slot_d[{idx, 3'b000} +: 8];
    end
  end

  slot_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT)
  ) u_wait (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .mreq_n      (mreq_n),
    .sel_valid   (sel_valid),
    .sel         (idx),
    .slot_ready  (slot_ready),
    .wait_n      (wait_n),
    .timeout_flag(timeout_flag),
    .force_ff    (force_ff)
  );

endmodule
